// File: rtl/nibble_seq_checker_if.sv
// Sample/status bundle between a nibble stream source and the sequence checker.
interface nibble_seq_checker_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_val;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;
   logic [WIDTH-1:0] expected;

   modport master (
      output in_valid, in_val, clear,
      input  locked, err_pulse, err_cnt, expected
   );

   modport slave (
      input  in_valid, in_val, clear,
      output locked, err_pulse, err_cnt, expected
   );
endinterface

// File: rtl/nibble_seq_checker.sv
// Sink-side monitor for an incrementing nibble stream: locks onto the sequence,
// flags and counts breaks while locked, and falls back to hunting after
// repeated breaks. Always resyncs its expectation to the received data.
module nibble_seq_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 2,
   parameter int ERR_W    = 8
) (
   input logic                 clk,
   input logic                 rst,
   nibble_seq_checker_if.slave bus
);

   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HUNT,
      S_LOCKED
   } state_t;

   state_t            state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [WIDTH-1:0]  exp_q, exp_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_pulse_q, err_pulse_d;
   logic              locked_q, locked_d;
   logic              match;

   assign match = (bus.in_val == exp_q);

   // State and datapath registers; reset discards lock, counts and expectation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         run_q       <= '0;
         miss_q      <= '0;
         exp_q       <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         exp_q       <= exp_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
      end
   end

   // Next-state logic: only valid beats advance anything; clear always wins on the counter.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      miss_d      = miss_q;
      exp_d       = exp_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      locked_d    = locked_q;

      if (bus.in_valid) begin
         // Resync to the received data on every sample, match or not.
         exp_d = bus.in_val + WIDTH'(1);
         unique case (state_q)
            S_IDLE: begin
               run_d   = '0;
               state_d = S_HUNT;
            end
            S_HUNT: begin
               if (match) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
                     state_d  = S_LOCKED;
                     locked_d = 1'b1;
                     miss_d   = '0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            S_LOCKED: begin
               if (match) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != {ERR_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  miss_d = miss_q + MISS_W'(1);
                  if (miss_q + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
                     state_d  = S_HUNT;
                     locked_d = 1'b0;
                     run_d    = '0;
                  end
               end
            end
            default: begin
               state_d  = S_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end

      if (bus.clear) begin
         err_cnt_d = '0;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      bus.locked    = locked_q;
      bus.err_pulse = err_pulse_q;
      bus.err_cnt   = err_cnt_q;
      bus.expected  = exp_q;
   end

endmodule
